zeroskip_feed_sched: RTL and testbench

//  Issue scheduler in front of zeroskip_pipe_wrapper_MAC1024. Accepts a tile command (mode, output count),

---
 rtl/zeroskip_feed_sched.sv | 195 +++++++++++++++++++
 tb/tb_zeroskip_feed_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroskip_feed_sched.sv
// -----------------------------------------------------------------------------
// zeroskip_feed_sched
//
// Issue scheduler in front of the zero-skip MAC wrapper. It accepts a tile
// command (mode, output-vector count), then admits matched act/znz beats from
// the upstream SRAM readers into the wrapper. The wrapper cannot stall, so
// issue is throttled by credits for the MAC input buffer downstream of it.
// In 8:32 mode two input beats form one output vector; the credit is reserved
// on the first beat of the pair and the output is counted on the second. After
// the last output the scheduler waits out the wrapper latency and pulses
// tile_done_o.
//
// Ports
//   clk, a_rst_n       clock, asynchronous active-low reset
//   enable             global stall; low freezes everything except credit return
//   cmd_vld_i/rdy_o    tile command handshake (ready only in IDLE while enabled)
//   cmd_mode_i         0 = 8:32 (two beats per output), 1 = 8:16 (one beat)
//   cmd_beats_i        output vectors in the tile; 0 is an empty tile
//   act_vld_i/rdy_o    upstream act beat; ready equals fire
//   znz_vld_i/rdy_o    upstream znz beat; ready equals fire
//   zs_act_vld_o       wrapper act valid (fire)
//   zs_znz_vld_o       wrapper znz valid (fire)
//   zs_nz_sel_o        wrapper group select, the mode latched at command accept
//   zs_enable_o        wrapper enable, follows enable
//   credit_ret_i       one MAC slot freed this cycle
//   tile_done_o        one-cycle pulse once the tile has drained
//   err_o              sticky: credit returned while the counter was full
// -----------------------------------------------------------------------------
module zeroskip_feed_sched #(
  parameter int CREDITS  = 4,
  parameter int BEATS_W  = 16,
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               a_rst_n,
  input  logic               enable,
  input  logic               cmd_vld_i,
  output logic               cmd_rdy_o,
  input  logic               cmd_mode_i,
  input  logic [BEATS_W-1:0] cmd_beats_i,
  input  logic               act_vld_i,
  output logic               act_rdy_o,
  input  logic               znz_vld_i,
  output logic               znz_rdy_o,
  output logic               zs_act_vld_o,
  output logic               zs_znz_vld_o,
  output logic               zs_nz_sel_o,
  output logic               zs_enable_o,
  input  logic               credit_ret_i,
  output logic               tile_done_o,
  output logic               err_o
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int DRN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  localparam logic [CNT_W-1:0]   CREDITS_MAX = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0]   ONE_C       = CNT_W'(1);
  localparam logic [BEATS_W-1:0] ONE_B       = BEATS_W'(1);
  localparam logic [DRN_W-1:0]   ONE_D       = DRN_W'(1);
  // DRAIN lasts PIPE_LAT+1 cycles; the pulse comes in the last one.
  localparam logic [DRN_W-1:0]   DRAIN_LAST  = DRN_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_H,
    S_RUN_Q0,
    S_RUN_Q1,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   credits_q, credits_d;
  logic [BEATS_W-1:0] out_cnt_q, out_cnt_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;

  logic issue_ok;
  logic fire;
  logic take_credit;
  logic last_out;
  logic done;

  // In RUN_Q1 the credit was already reserved by the first beat of the pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    issue_ok = 1'b0;
    case (state_q)
      S_RUN_H, S_RUN_Q0: issue_ok = (credits_q != '0);
      S_RUN_Q1:          issue_ok = 1'b1;
      default:           issue_ok = 1'b0;
    endcase
  end

  assign fire        = enable & act_vld_i & znz_vld_i & issue_ok;
  assign take_credit = fire & ((state_q == S_RUN_H) | (state_q == S_RUN_Q0));
  assign last_out    = ((out_cnt_q + ONE_B) == beats_q);

  // Next-state and tile bookkeeping; nothing advances while enable is low.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beats_d   = beats_q;
    out_cnt_d = out_cnt_q;
    drain_d   = drain_q;
    done      = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_vld_i) begin
            mode_d    = cmd_mode_i;
            beats_d   = cmd_beats_i;
            out_cnt_d = '0;
            drain_d   = '0;
            if (cmd_beats_i == '0)  state_d = S_DRAIN;
            else if (cmd_mode_i)    state_d = S_RUN_H;
            else                    state_d = S_RUN_Q0;
          end
        end
        S_RUN_H: begin
          if (fire) begin
            out_cnt_d = out_cnt_q + ONE_B;
            if (last_out) state_d = S_DRAIN;
          end
        end
        S_RUN_Q0: begin
          if (fire) state_d = S_RUN_Q1;
        end
        S_RUN_Q1: begin
          if (fire) begin
            out_cnt_d = out_cnt_q + ONE_B;
            state_d   = last_out ? S_DRAIN : S_RUN_Q0;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            drain_d = drain_q + ONE_D;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Credit counter keeps counting returns even while stalled. A reservation and
  // a return in the same cycle cancel. A return at full count is an error and
  // is otherwise ignored.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (take_credit && !credit_ret_i) begin
      credits_d = credits_q - ONE_C;
    end else if (!take_credit && credit_ret_i) begin
      if (credits_q == CREDITS_MAX) err_d = 1'b1;
      else                          credits_d = credits_q + ONE_C;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q   <= S_IDLE;
      credits_q <= CREDITS_MAX;
      out_cnt_q <= '0;
      beats_q   <= '0;
      drain_q   <= '0;
      mode_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      out_cnt_q <= out_cnt_d;
      beats_q   <= beats_d;
      drain_q   <= drain_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
    end
  end

  assign cmd_rdy_o    = (state_q == S_IDLE) & enable;
  assign act_rdy_o    = fire;
  assign znz_rdy_o    = fire;
  assign zs_act_vld_o = fire;
  assign zs_znz_vld_o = fire;
  assign zs_nz_sel_o  = mode_q;
  assign zs_enable_o  = enable;
  assign tile_done_o  = done;
  assign err_o        = err_q;

endmodule

// File: tb/tb_zeroskip_feed_sched.sv
// -----------------------------------------------------------------------------
// tb_zeroskip_feed_sched
//
// Bench for zeroskip_feed_sched. A behavioural model tracks the tile as a
// count of input beats issued against the beats the tile needs, plus a credit
// pool and a drain countdown. Every cycle the DUT outputs are compared with
// the model; directed scenarios add hand-computed expectations on top.
// -----------------------------------------------------------------------------
module tb_zeroskip_feed_sched;

  localparam int CREDITS  = 4;
  localparam int BEATS_W  = 16;
  localparam int PIPE_LAT = 1;

  logic               clk;
  logic               a_rst_n;
  logic               enable;
  logic               cmd_vld_i;
  logic               cmd_rdy_o;
  logic               cmd_mode_i;
  logic [BEATS_W-1:0] cmd_beats_i;
  logic               act_vld_i;
  logic               act_rdy_o;
  logic               znz_vld_i;
  logic               znz_rdy_o;
  logic               zs_act_vld_o;
  logic               zs_znz_vld_o;
  logic               zs_nz_sel_o;
  logic               zs_enable_o;
  logic               credit_ret_i;
  logic               tile_done_o;
  logic               err_o;

  zeroskip_feed_sched #(
    .CREDITS (CREDITS),
    .BEATS_W (BEATS_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk         (clk),
    .a_rst_n     (a_rst_n),
    .enable      (enable),
    .cmd_vld_i   (cmd_vld_i),
    .cmd_rdy_o   (cmd_rdy_o),
    .cmd_mode_i  (cmd_mode_i),
    .cmd_beats_i (cmd_beats_i),
    .act_vld_i   (act_vld_i),
    .act_rdy_o   (act_rdy_o),
    .znz_vld_i   (znz_vld_i),
    .znz_rdy_o   (znz_rdy_o),
    .zs_act_vld_o(zs_act_vld_o),
    .zs_znz_vld_o(zs_znz_vld_o),
    .zs_nz_sel_o (zs_nz_sel_o),
    .zs_enable_o (zs_enable_o),
    .credit_ret_i(credit_ret_i),
    .tile_done_o (tile_done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Behavioural model: phase 0 idle, 1 issuing, 2 draining.
  int m_phase;
  int m_credits;
  bit m_err;
  bit m_mode;
  int m_total;
  int m_issued;
  int m_drain_left;

  // Values seen on the most recent step.
  logic s_fire;
  logic s_done;
  logic s_rdy;
  int   s_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_credits    = CREDITS;
    m_err        = 1'b0;
    m_mode       = 1'b1;
    m_total      = 0;
    m_issued     = 0;
    m_drain_left = 0;
  endtask

  // One clock cycle: drive, compare all outputs with the model, advance model.
  task automatic step(input logic en, input logic cv, input logic cm, input logic [BEATS_W-1:0] cb,
                      input logic av, input logic zv, input logic cr);
    bit need_credit, can_issue, e_fire, e_rdy, e_done;
    logic [8:0] got, exp;
    enable       = en;
    cmd_vld_i    = cv;
    cmd_mode_i   = cm;
    cmd_beats_i  = cb;
    act_vld_i    = av;
    znz_vld_i    = zv;
    credit_ret_i = cr;
    #1;
    // 8:16 needs a credit for every beat; 8:32 only for the first beat of a pair.
    need_credit = m_mode ? 1'b1 : ((m_issued % 2) == 0);
    can_issue   = (m_phase == 1) && (need_credit ? (m_credits > 0) : 1'b1);
    e_fire      = en && av && zv && can_issue;
    e_rdy       = (m_phase == 0) && en;
    e_done      = (m_phase == 2) && en && (m_drain_left == 1);
    exp = {e_rdy, e_fire, e_fire, e_fire, e_fire, m_mode, en, e_done, m_err};
    got = {cmd_rdy_o, act_rdy_o, znz_rdy_o, zs_act_vld_o, zs_znz_vld_o,
           zs_nz_sel_o, zs_enable_o, tile_done_o, err_o};
    check("cycle_outputs{rdy,act,znz,zact,zznz,sel,en,done,err}", 32'(got), 32'(exp));
    s_fire = act_rdy_o;
    s_done = tile_done_o;
    s_rdy  = cmd_rdy_o;
    s_cyc  = cyc;
    cyc++;
    // Advance the model to its post-edge state.
    if (e_fire && need_credit && !cr) m_credits--;
    else if (!(e_fire && need_credit) && cr) begin
      if (m_credits == CREDITS) m_err = 1'b1;
      else m_credits++;
    end
    if (m_phase == 0) begin
      if (en && cv) begin
        m_mode       = cm;
        m_total      = int'(cb) * (cm ? 1 : 2);
        m_issued     = 0;
        m_phase      = (cb == 0) ? 2 : 1;
        m_drain_left = PIPE_LAT + 1;
      end
    end else if (m_phase == 1) begin
      if (e_fire) begin
        m_issued++;
        if (m_issued == m_total) m_phase = 2;
      end
    end else if (en) begin
      if (m_drain_left == 1) m_phase = 0;
      else m_drain_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic mode, input logic [BEATS_W-1:0] beats, output int at);
    step(1'b1, 1'b1, mode, beats, 1'b0, 1'b0, 1'b0);
    check("cmd_accept_ready", 32'(s_rdy), 32'd1);
    at = s_cyc;
  endtask

  task automatic run_until_done(input int budget, input logic cr, output int fires,
                                output int last_fire, output int done_at);
    fires = 0; last_fire = -1; done_at = -1;
    for (int i = 0; i < budget && done_at < 0; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, cr);
      if (s_fire) begin fires++; last_fire = s_cyc; end
      if (s_done) done_at = s_cyc;
    end
    if (done_at < 0) check("tile_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic refill();
    for (int i = 0; i < CREDITS + 2; i++)
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, (m_credits < CREDITS));
  endtask

  task automatic do_reset();
    a_rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_sel", 32'(zs_nz_sel_o), 32'd1);
    check("reset_done", 32'(tile_done_o), 32'd0);
    check("reset_act_rdy", 32'(act_rdy_o), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
  endtask

  int at, fires, last_fire, done_at, cnt, cnt2;

  initial begin
    a_rst_n = 1'b0; enable = 1'b1; cmd_vld_i = 1'b0; cmd_mode_i = 1'b0; cmd_beats_i = '0;
    act_vld_i = 1'b1; znz_vld_i = 1'b1; credit_ret_i = 1'b0;
    @(negedge clk);
    do_reset();

    // A: 8:16, three outputs, no returns.
    accept(1'b1, 16'd3, at);
    run_until_done(20, 1'b0, fires, last_fire, done_at);
    check("A_fires", 32'(fires), 32'd3);
    check("A_done_after_last_fire", 32'(done_at - last_fire), 32'd2);
    check("A_model_credits", 32'(m_credits), 32'd1);
    refill();

    // B: 8:32, two outputs -> four beats, two credits.
    accept(1'b0, 16'd2, at);
    run_until_done(20, 1'b0, fires, last_fire, done_at);
    check("B_fires", 32'(fires), 32'd4);
    check("B_done_after_last_fire", 32'(done_at - last_fire), 32'd2);
    check("B_model_credits", 32'(m_credits), 32'd2);
    refill();

    // C: 8:16, six outputs, credits run dry at four.
    accept(1'b1, 16'd6, at);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_fire) cnt++;
    end
    check("C_fires_before_return", 32'(cnt), 32'd4);
    cnt = 0;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    if (s_fire) cnt++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_fire) cnt++;
    end
    check("C_fires_after_one_return", 32'(cnt), 32'd1);
    run_until_done(30, 1'b1, fires, last_fire, done_at);
    check("C_remaining_fires", 32'(fires), 32'd1);
    refill();

    // D: empty tile.
    accept(1'b1, 16'd0, at);
    run_until_done(10, 1'b0, fires, last_fire, done_at);
    check("D_fires", 32'(fires), 32'd0);
    check("D_done_after_accept", 32'(done_at - at), 32'd2);

    // E: stall in the second beat of a pair.
    accept(1'b0, 16'd3, at);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("E_first_beat_fires", 32'(s_fire), 32'd1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_fire) cnt++;
    end
    check("E_stalled_fires", 32'(cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("E_resume_fires", 32'(s_fire), 32'd1);
    run_until_done(30, 1'b0, fires, last_fire, done_at);
    check("E_remaining_fires", 32'(fires), 32'd4);
    refill();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           BEATS_W'($urandom_range(0, 5)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           (m_credits < CREDITS) && ($urandom_range(0, 2) == 0));
    end
    refill();
    for (int i = 0; i < 20 && m_phase != 0; i++)
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, (m_credits < CREDITS));
    refill();

    // F: reset in the middle of a pair, then an excess credit return.
    accept(1'b0, 16'd3, at);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    do_reset();
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (s_fire) cnt++;
      if (s_done) cnt2++;
    end
    check("F_fires_after_reset", 32'(cnt), 32'd0);
    check("F_done_after_reset", 32'(cnt2), 32'd0);
    check("F_idle_ready", 32'(s_rdy), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("F_err_sticky", 32'(err_o), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
